// File: rtl/boot_loader.sv
// Byte-stream boot loader for MIPS_Single_Cycle.
// Takes a length-prefixed image over valid/ready and packs it into big-endian
// 32-bit words for instruction memory. The CPU is held in reset until the
// trailing XOR checksum matches.
module boot_loader #(
    parameter int unsigned ADDR_WIDTH    = 8,
    parameter int unsigned BASE_ADDR     = 0,
    parameter int unsigned RELEASE_DELAY = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    output logic                  rx_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  cpu_reset,
    output logic                  done,
    output logic                  error
);

    // Word counter is one bit wider than the 16-bit length so N == 2**ADDR_WIDTH fits
    localparam int unsigned CNT_W     = 17;
    localparam int unsigned LEN_W     = 16;
    localparam int unsigned MAX_WORDS = 32'(1) << ADDR_WIDTH;
    localparam int unsigned REL_W     = $clog2(RELEASE_DELAY + 1);

    typedef enum logic [2:0] {
        S_INIT,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_CSUM,
        S_RELEASE,
        S_RUN,
        S_ERROR
    } state_e;

    state_e                state_q,      state_d;
    logic [LEN_W-1:0]      len_q,        len_d;
    logic [1:0]            byte_cnt_q,   byte_cnt_d;
    logic [CNT_W-1:0]      word_cnt_q,   word_cnt_d;
    logic [31:0]           shift_q,      shift_d;
    logic [7:0]            acc_q,        acc_d;
    logic                  pend_q,       pend_d;
    logic [REL_W-1:0]      rel_cnt_q,    rel_cnt_d;

    logic                  rx_ready_q,   rx_ready_d;
    logic                  imem_we_q,    imem_we_d;
    logic [ADDR_WIDTH-1:0] imem_addr_q,  imem_addr_d;
    logic [31:0]           imem_wdata_q, imem_wdata_d;
    logic                  cpu_reset_q,  cpu_reset_d;
    logic                  done_q,       done_d;
    logic                  error_q,      error_d;

    logic                  xfer;
    logic [LEN_W-1:0]      len_new;
    logic [CNT_W-1:0]      word_cnt_inc;

    assign xfer = rx_valid & rx_ready_q;

    // Next-state, datapath and registered-output computation
    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        byte_cnt_d   = byte_cnt_q;
        word_cnt_d   = word_cnt_q;
        shift_d      = shift_q;
        acc_d        = acc_q;
        pend_d       = 1'b0;
        rel_cnt_d    = rel_cnt_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        len_new      = {len_q[LEN_W-1:8], rx_data};
        word_cnt_inc = word_cnt_q + CNT_W'(1);

        // A word completed on the previous edge is written one cycle later;
        // word_cnt_q has already advanced, so the index is word_cnt_q - 1.
        if (pend_q) begin
            imem_we_d    = 1'b1;
            imem_addr_d  = ADDR_WIDTH'(BASE_ADDR)
                         + ADDR_WIDTH'(word_cnt_q - CNT_W'(1));
            imem_wdata_d = shift_q;
        end

        case (state_q)
            S_INIT: begin
                state_d = S_LEN_HI;
            end
            S_LEN_HI: begin
                if (xfer) begin
                    len_d   = {rx_data, 8'h00};
                    state_d = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (xfer) begin
                    len_d = len_new;
                    if (32'(len_new) > MAX_WORDS) begin
                        state_d = S_ERROR;
                    end else if (len_new == '0) begin
                        state_d = S_CSUM;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (xfer) begin
                    shift_d    = {shift_q[23:0], rx_data};
                    acc_d      = acc_q ^ rx_data;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        pend_d     = 1'b1;
                        word_cnt_d = word_cnt_inc;
                        if (word_cnt_inc == CNT_W'(len_q)) begin
                            state_d = S_CSUM;
                        end
                    end
                end
            end
            S_CSUM: begin
                if (xfer) begin
                    if (rx_data == acc_q) begin
                        state_d   = S_RELEASE;
                        rel_cnt_d = REL_W'(1);
                    end else begin
                        state_d = S_ERROR;
                    end
                end
            end
            S_RELEASE: begin
                if (rel_cnt_q == REL_W'(RELEASE_DELAY)) begin
                    state_d = S_RUN;
                end else begin
                    rel_cnt_d = rel_cnt_q + REL_W'(1);
                end
            end
            S_RUN: begin
                state_d = S_RUN;
            end
            S_ERROR: begin
                state_d = S_ERROR;
            end
            default: begin
                state_d = S_ERROR;
            end
        endcase

        // Status outputs follow the state being entered so they change on the same edge
        rx_ready_d  = (state_d == S_LEN_HI) || (state_d == S_LEN_LO)
                   || (state_d == S_DATA)   || (state_d == S_CSUM);
        cpu_reset_d = (state_d != S_RUN);
        done_d      = (state_d == S_RUN);
        error_d     = (state_d == S_ERROR);
    end

    // State and output registers with asynchronous reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_INIT;
            len_q        <= '0;
            byte_cnt_q   <= '0;
            word_cnt_q   <= '0;
            shift_q      <= '0;
            acc_q        <= '0;
            pend_q       <= 1'b0;
            rel_cnt_q    <= '0;
            rx_ready_q   <= 1'b0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= ADDR_WIDTH'(BASE_ADDR);
            imem_wdata_q <= '0;
            cpu_reset_q  <= 1'b1;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            byte_cnt_q   <= byte_cnt_d;
            word_cnt_q   <= word_cnt_d;
            shift_q      <= shift_d;
            acc_q        <= acc_d;
            pend_q       <= pend_d;
            rel_cnt_q    <= rel_cnt_d;
            rx_ready_q   <= rx_ready_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            cpu_reset_q  <= cpu_reset_d;
            done_q       <= done_d;
            error_q      <= error_d;
        end
    end

    assign rx_ready   = rx_ready_q;
    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign cpu_reset  = cpu_reset_q;
    assign done       = done_q;
    assign error      = error_q;

endmodule

// File: tb/tb_boot_loader.sv
// Self-checking bench for boot_loader: directed images plus randomized images,
// valid gaps and mid-load resets, checked against a stream-level model.
`timescale 1ns/1ps
module tb_boot_loader;

    localparam int unsigned AW   = 8;
    localparam int unsigned BASE = 0;
    localparam int unsigned RD   = 4;

    typedef logic [7:0] bq_t [$];
    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          rx_valid = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          cpu_reset;
    logic          done;
    logic          error;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    wr_t exp_wr[$];
    int  exp_cyc[$];

    boot_loader #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE), .RELEASE_DELAY(RD)) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .rx_ready  (rx_ready),
        .imem_we   (imem_we),
        .imem_addr (imem_addr),
        .imem_wdata(imem_wdata),
        .cpu_reset (cpu_reset),
        .done      (done),
        .error     (error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Every write strobe must match the next expected (addr, data, cycle)
    always @(negedge clk) begin
        if (!reset && imem_we) begin
            if (exp_wr.size() == 0 || exp_cyc.size() == 0) begin
                check("unexpected_write", 64'(imem_we), 64'd0);
            end else begin
                wr_t w;
                int  c;
                w = exp_wr.pop_front();
                c = exp_cyc.pop_front();
                check("wr_addr",  64'(imem_addr),  64'(w.addr));
                check("wr_data",  64'(imem_wdata), 64'(w.data));
                check("wr_cycle", 64'(cyc),        64'(c));
            end
        end
    end

    task automatic check_reset_values(input string tag);
        check({tag, "_rx_ready"},  64'(rx_ready),   64'd0);
        check({tag, "_imem_we"},   64'(imem_we),    64'd0);
        check({tag, "_imem_addr"}, 64'(imem_addr),  64'(BASE));
        check({tag, "_imem_wdata"},64'(imem_wdata), 64'd0);
        check({tag, "_cpu_reset"}, 64'(cpu_reset),  64'd1);
        check({tag, "_done"},      64'(done),       64'd0);
        check({tag, "_error"},     64'(error),      64'd0);
    endtask

    // Offer one byte until it is accepted; returns the edge count of the handshake
    task automatic send_byte(input logic [7:0] b, input int gap_pct, output int hs_edge);
        bit accepted = 1'b0;
        hs_edge = -1;
        for (int t = 0; t < 200 && !accepted; t++) begin
            @(negedge clk);
            if (int'($urandom_range(99)) < gap_pct) begin
                rx_valid = 1'b0;
                rx_data  = 8'($urandom);
            end else begin
                rx_valid = 1'b1;
                rx_data  = b;
                if (rx_ready) begin
                    @(posedge clk);
                    #1;
                    hs_edge  = cyc;
                    accepted = 1'b1;
                end
            end
        end
        if (!accepted) check("rx_ready_timeout", 64'(rx_ready), 64'd1);
    endtask

    // One complete load attempt; abort_at >= 0 resets after that many data bytes
    task automatic run_load(input string name, input bq_t s, input int gap_pct, input int abort_at);
        int            n;
        bit            too_big;
        logic [7:0]    csum;
        bit            ok;
        int            last;
        int            hs;
        logic [31:0]   word;

        reset    = 1'b1;
        rx_valid = 1'b0;
        exp_wr.delete();
        exp_cyc.delete();
        repeat (2) @(negedge clk);
        check_reset_values({name, "_rst"});
        reset = 1'b0;
        @(negedge clk);
        check({name, "_ready_after_init"}, 64'(rx_ready), 64'd1);

        // Reference model: decode the stream into expected writes and outcome
        n       = int'({s[0], s[1]});
        too_big = (n > (1 << AW));
        csum    = 8'h00;
        if (!too_big) begin
            for (int w = 0; w < n; w++) begin
                word = {s[2+4*w], s[3+4*w], s[4+4*w], s[5+4*w]};
                csum = csum ^ s[2+4*w] ^ s[3+4*w] ^ s[4+4*w] ^ s[5+4*w];
                if (abort_at < 0 || (w + 1) * 4 <= abort_at)
                    exp_wr.push_back('{addr: AW'((BASE + w) % (1 << AW)), data: word});
            end
        end
        ok = !too_big && (s[2+4*n] == csum);

        if (abort_at >= 0)  last = 1 + abort_at;
        else if (too_big)   last = 1;
        else                last = 2 + 4 * n;

        hs = 0;
        for (int i = 0; i <= last; i++) begin
            send_byte(s[i], gap_pct, hs);
            if (i >= 2 && i < 2 + 4 * n && ((i - 2) % 4) == 3) exp_cyc.push_back(hs + 1);
        end

        if (abort_at >= 0) begin
            reset = 1'b1;
            #1;
            check_reset_values({name, "_abort"});
            check({name, "_abort_writes_left"}, 64'(exp_wr.size()), 64'd0);
            @(negedge clk);
            rx_valid = 1'b0;
            return;
        end

        @(negedge clk);
        rx_valid = 1'b0;
        if (ok) begin
            repeat (RD - 1) @(negedge clk);
            check({name, "_cpu_reset_held"}, 64'(cpu_reset), 64'd1);
            check({name, "_done_early"},     64'(done),      64'd0);
            @(negedge clk);
            check({name, "_cpu_reset_rel"},  64'(cpu_reset), 64'd0);
            check({name, "_done"},           64'(done),      64'd1);
        end else begin
            check({name, "_error"},     64'(error),     64'd1);
            check({name, "_cpu_reset"}, 64'(cpu_reset), 64'd1);
            check({name, "_done"},      64'(done),      64'd0);
        end
        check({name, "_rx_ready_off"}, 64'(rx_ready), 64'd0);

        repeat (8) @(negedge clk);
        check({name, "_writes_left"}, 64'(exp_wr.size()), 64'd0);
        check({name, "_final_done"},  64'(done),      64'(ok));
        check({name, "_final_error"}, 64'(error),     64'(!ok));
        check({name, "_final_cpurst"},64'(cpu_reset), 64'(!ok));
        check({name, "_final_ready"}, 64'(rx_ready),  64'd0);
    endtask

    function automatic bq_t test1_stream(input logic [7:0] cs);
        bq_t q;
        logic [7:0] d [8] = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h0A};
        q.push_back(8'h00);
        q.push_back(8'h02);
        foreach (d[i]) q.push_back(d[i]);
        q.push_back(cs);
        return q;
    endfunction

    function automatic bq_t rand_stream(input int n, input bit corrupt);
        bq_t q;
        logic [7:0] x = 8'h00;
        logic [7:0] b;
        q.push_back(8'(n >> 8));
        q.push_back(8'(n));
        if (n <= (1 << AW)) begin
            for (int i = 0; i < 4 * n; i++) begin
                b = 8'($urandom);
                x = x ^ b;
                q.push_back(b);
            end
            q.push_back(corrupt ? (x ^ 8'(1 + $urandom_range(254))) : x);
        end
        return q;
    endfunction

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bq_t s;
        bq_t z;
        int  n;

        run_load("t1_good",     test1_stream(8'h0E), 0, -1);
        run_load("t2_badcsum",  test1_stream(8'h0F), 0, -1);
        z.delete();
        z.push_back(8'h00); z.push_back(8'h00); z.push_back(8'h00);
        run_load("t3_empty",    z, 0, -1);
        z.delete();
        z.push_back(8'h01); z.push_back(8'h01);
        run_load("t4_toobig",   z, 0, -1);
        run_load("t5_gaps",     test1_stream(8'h0E), 50, -1);
        run_load("t6_abort",    test1_stream(8'h0E), 0, 2);
        run_load("t6_replay",   test1_stream(8'h0E), 0, -1);
        run_load("full_image",  rand_stream(1 << AW, 1'b0), 20, -1);

        for (int it = 0; it < 16; it++) begin
            int sel = int'($urandom_range(9));
            if (sel < 7)      n = int'($urandom_range(8));
            else if (sel < 9) n = (1 << AW) + 1 + int'($urandom_range(65535 - (1 << AW) - 1));
            else              n = 1 << AW;
            s = rand_stream(n, ($urandom_range(99) < 30));
            if (n >= 2 && n <= 8 && $urandom_range(3) == 0) begin
                int m;
                m = int'($urandom_range(4 * n - 1));
                if ((m % 4) == 0) m = m + 1;
                run_load("rand_abort", s, 50, m);
            end else begin
                run_load("rand", s, ($urandom_range(1) == 1) ? 50 : 0, -1);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
